// File: rtl/test_stream_pkg.sv
// Shared constants and helpers for the test_stream FIFO.
// Holds the address-width function and the default geometry.
package test_stream_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  localparam int FIFO_WIDTH = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = clog2(FIFO_DEPTH);
  localparam int PTR_W      = ADDR_W + 1;

endpackage

// File: rtl/test_fifo_regfile.sv
// DEPTH x WIDTH storage array for the stream FIFO.
// Provides one synchronous write port and one combinational read port.
module test_fifo_regfile
  import test_stream_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int AWIDTH = clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is reset so o_data reads 0 out of reset; this keeps it
  // in flops rather than RAM, which is acceptable at this small depth.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/test_stream_fifo.sv
// First-word-fall-through valid/ready FIFO feeding the test_module_0 stage.
// Define TEST_STREAM_FIFO_LEVEL_EN to add the o_level / o_almost_full ports.
module test_stream_fifo
  import test_stream_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_valid,
  input  logic [WIDTH-1:0]        i_data,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic [WIDTH-1:0]        o_data,
  input  logic                    i_ready
`ifdef TEST_STREAM_FIFO_LEVEL_EN
  ,
  output logic [clog2(DEPTH):0]   o_level,
  output logic                    o_almost_full
`endif
);

  localparam int ADDR_BITS = clog2(DEPTH);
  localparam int PTR_BITS  = ADDR_BITS + 1;

  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;

  // The extra wrap bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]) &&
                 (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]);

  assign o_ready = !full;
  assign o_valid = !empty;
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  // NOTE: sequential state uses non-blocking assignments so every pointer
  // update sees the pre-edge values of the other pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
    end
  end

  test_fifo_regfile #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .AWIDTH (ADDR_BITS)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .we      (push && !i_flush),
    .waddr   (wr_ptr[ADDR_BITS-1:0]),
    .wdata   (i_data),
    .raddr   (rd_ptr[ADDR_BITS-1:0]),
    .rdata   (o_data)
  );

`ifdef TEST_STREAM_FIFO_LEVEL_EN
  // Modulo subtraction of the wrap-extended pointers yields 0..DEPTH.
  assign o_level       = wr_ptr - rd_ptr;
  assign o_almost_full = (o_level >= PTR_BITS'(DEPTH - 1));
`endif

endmodule

// File: tb/tb_test_stream_fifo.sv
// Directed self-checking bench for test_stream_fifo (DEPTH=4, WIDTH=10).
// Level checks are included when TEST_STREAM_FIFO_LEVEL_EN is defined.
module tb_test_stream_fifo;

  localparam int WIDTH = 10;
  localparam int DEPTH = 4;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_flush;
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             i_ready;
`ifdef TEST_STREAM_FIFO_LEVEL_EN
  logic [test_stream_pkg::PTR_W-1:0] o_level;
  logic                              o_almost_full;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  test_stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready)
`ifdef TEST_STREAM_FIFO_LEVEL_EN
    ,
    .o_level       (o_level),
    .o_almost_full (o_almost_full)
`endif
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;

    // Reset held for 3 cycles, then idle.
    repeat (3) tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_data",  32'(o_data),  32'd0);
    i_rst_n = 1'b1;
    tick();
    tick();
    check("idle_valid", 32'(o_valid), 32'd0);
    check("idle_ready", 32'(o_ready), 32'd1);
    check("idle_data",  32'(o_data),  32'd0);
`ifdef TEST_STREAM_FIFO_LEVEL_EN
    check("idle_level", 32'(o_level),       32'd0);
    check("idle_af",    32'(o_almost_full), 32'd0);
`endif

    // Single word with fall-through latency of one edge.
    i_valid = 1'b1;
    i_data  = 10'h155;
    tick();
    i_valid = 1'b0;
    check("single_valid", 32'(o_valid), 32'd1);
    check("single_data",  32'(o_data),  32'h155);
    tick();
    check("single_hold", 32'(o_data), 32'h155);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("single_pop_valid", 32'(o_valid), 32'd0);

    // Fill to DEPTH=4, reject a 5th word, then drain in order.
    for (int k = 1; k <= DEPTH; k++) begin
      i_valid = 1'b1;
      i_data  = WIDTH'(k);
      tick();
    end
    check("full_ready", 32'(o_ready), 32'd0);
    check("full_valid", 32'(o_valid), 32'd1);
    check("full_head",  32'(o_data),  32'd1);
    i_data = 10'd5;
    tick();
    check("full_reject_ready", 32'(o_ready), 32'd0);
    check("full_reject_head",  32'(o_data),  32'd1);
    i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    check("pop_from_full_ready", 32'(o_ready), 32'd1);
    check("drain_2", 32'(o_data), 32'd2);
    tick();
    check("drain_3", 32'(o_data), 32'd3);
    tick();
    check("drain_4", 32'(o_data), 32'd4);
    tick();
    check("drain_empty", 32'(o_valid), 32'd0);

    // Continuous streaming past several pointer wraps.
    i_ready = 1'b1;
    i_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_data = WIDTH'(k);
      tick();
      check($sformatf("stream_valid_%0d", k), 32'(o_valid), 32'd1);
      check($sformatf("stream_data_%0d", k),  32'(o_data),  32'(k));
    end
    i_valid = 1'b0;
    tick();
    check("stream_end_valid", 32'(o_valid), 32'd0);
    i_ready = 1'b0;

    // Flush with a concurrent push: everything, including the push, is dropped.
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_data  = WIDTH'(10'h0A0 + k);
      tick();
    end
`ifdef TEST_STREAM_FIFO_LEVEL_EN
    check("level_3",    32'(o_level),       32'd3);
    check("level_3_af", 32'(o_almost_full), 32'd1);
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("level_2",    32'(o_level),       32'd2);
    check("level_2_af", 32'(o_almost_full), 32'd0);
    i_valid = 1'b1;
`endif
    check("preflush_valid", 32'(o_valid), 32'd1);
    i_flush = 1'b1;
    i_data  = 10'h3FF;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_ready", 32'(o_ready), 32'd1);
`ifdef TEST_STREAM_FIFO_LEVEL_EN
    check("flush_level", 32'(o_level), 32'd0);
`endif
    tick();
    check("flush_dropped", 32'(o_valid), 32'd0);

    // Refill two words, then assert reset asynchronously mid-cycle.
    i_valid = 1'b1;
    i_data  = 10'h021;
    tick();
    i_data  = 10'h022;
    tick();
    i_valid = 1'b0;
    check("refill_valid", 32'(o_valid), 32'd1);
    check("refill_head",  32'(o_data),  32'h021);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(o_valid), 32'd0);
    check("async_rst_ready", 32'(o_ready), 32'd1);
    check("async_rst_data",  32'(o_data),  32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    check("post_rst_valid", 32'(o_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
